// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_pkg
// Description : Shared encodings for the instruction fetch stage:
//               next-PC select codes, fetch FSM states and instruction width.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_pkg;

    // Width of one instruction word
    localparam int c_INST_W = 32;

    // Next-PC select encodings driven by the decode stage
    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_J   = 2'b10,
        PC_JR  = 2'b11
    } pc_sel_e;

    // Fetch FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_REQ   = 2'b01,
        S_VALID = 2'b10
    } fetch_state_e;

endpackage : inst_fetch_pkg
`default_nettype wire

// File: rtl/inst_fetch_pc_next_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_gen
// Description : Combinational next-PC generator. Selects sequential, branch,
//               jump or register-indirect target and flags a misaligned jr.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_gen
    import inst_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] imm_data,
    input  logic [27:0] addr_data,
    input  logic [31:0] jr_addr,
    output logic [31:0] next_pc,
    output logic        jr_misaligned
);

    logic [31:0] w_pc_plus4;

    // All arithmetic wraps modulo 2^32 by construction of the 32-bit adders
    assign w_pc_plus4 = pc + 32'd4;

    // Target selection; jr drops the low address bits and reports if any were set
    always_comb begin
        next_pc       = w_pc_plus4;
        jr_misaligned = 1'b0;
        case (pc_sel_e'(pc_sel))
            PC_SEQ:  next_pc = w_pc_plus4;
            PC_BR:   next_pc = w_pc_plus4 + (imm_data << 2);
            PC_J:    next_pc = {w_pc_plus4[31:28], addr_data};
            PC_JR: begin
                next_pc       = {jr_addr[31:2], 2'b00};
                jr_misaligned = |jr_addr[1:0];
            end
            default: next_pc = w_pc_plus4;
        endcase
    end

endmodule : pc_next_gen
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Instruction fetch stage. Issues one memory request per
//               instruction, holds the returned word for decode, handles
//               stalls, next-PC selection and a sticky fetch error for
//               memory timeouts and misaligned register jumps.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_TIMEOUT = 16
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          pc_sel,
    input  logic [31:0]         imm_data,
    input  logic [27:0]         addr_data,
    input  logic [31:0]         jr_addr,
    input  logic                stall,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic                imem_ready,
    input  logic [c_INST_W-1:0] imem_rdata,
    output logic [c_INST_W-1:0] inst_data,
    output logic                inst_valid,
    output logic [31:0]         pc_out,
    output logic [31:0]         pc_plus4,
    output logic                fetch_err
);

    // Counter only needs to reach IMEM_TIMEOUT-1 before it wraps back to zero
    localparam int                 c_CNT_W    = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(IMEM_TIMEOUT - 1);

    fetch_state_e          r_state;
    fetch_state_e          w_next_state;
    logic [31:0]           r_pc;
    logic [c_INST_W-1:0]   r_inst;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_err;
    logic [31:0]           w_next_pc;
    logic                  w_jr_misaligned;
    logic                  w_accept;
    logic                  w_advance;
    logic                  w_waiting;

    // Next-PC datapath
    pc_next_gen u_pc_next_gen (
        .pc            (r_pc),
        .pc_sel        (pc_sel),
        .imm_data      (imm_data),
        .addr_data     (addr_data),
        .jr_addr       (jr_addr),
        .next_pc       (w_next_pc),
        .jr_misaligned (w_jr_misaligned)
    );

    // Response accepted only while a request is outstanding
    assign w_accept  = (r_state == S_REQ) && imem_ready;
    assign w_waiting = (r_state == S_REQ) && !imem_ready;
    // Decode consumes the held instruction and the PC moves on
    assign w_advance = (r_state == S_VALID) && !stall;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state and handshake outputs
    always_comb begin
        w_next_state = r_state;
        imem_req     = 1'b0;
        inst_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next_state = S_REQ;
            end
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    w_next_state = S_VALID;
                end
            end
            S_VALID: begin
                inst_valid = 1'b1;
                if (!stall) begin
                    w_next_state = S_REQ;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // PC and instruction holding registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc   <= RESET_PC;
            r_inst <= '0;
        end else begin
            if (w_accept) begin
                r_inst <= imem_rdata;
            end
            if (w_advance) begin
                r_pc <= w_next_pc;
            end
        end
    end

    // Wait-cycle counter; cleared outside S_REQ so each request starts fresh
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_waiting) begin
            r_cnt <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + c_CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Sticky error: memory timeout or misaligned jr; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if ((w_waiting && (r_cnt == c_CNT_LAST)) ||
                     (w_advance && w_jr_misaligned)) begin
            r_err <= 1'b1;
        end
    end

    assign imem_addr = r_pc;
    assign pc_out    = r_pc;
    assign pc_plus4  = r_pc + 32'd4;
    assign inst_data = r_inst;
    assign fetch_err = r_err;

endmodule : inst_fetch
`default_nettype wire

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter IMEM_TIMEOUT, default 16, maximum wait cycles for imem_ready before fetch error.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 pc_sel  input  2  next-PC select: 00 seq, 01 branch, 10 jump, 11 jr.
REQ-006 imm_data  input  32  sign/zero-extended immediate from decode stage.
REQ-007 addr_data  input  28  jump target {instr_index, 2'b00} from decode stage.
REQ-008 jr_addr  input  32  register-sourced target for jr.
REQ-009 stall  input  1  hold current instruction and PC.
REQ-010 imem_req  output  1  instruction memory read request.
REQ-011 imem_addr  output  32  instruction memory word address (byte address, low 2 bits 00).
REQ-012 imem_ready  input  1  memory response valid; imem_rdata sampled this cycle.
REQ-013 imem_rdata  input  32  instruction word from memory.
REQ-014 inst_data  output  32  registered instruction to decode stage.
REQ-015 inst_valid  output  1  inst_data valid for consumption this cycle.
REQ-016 pc_out  output  32  PC of inst_data.
REQ-017 pc_plus4  output  32  pc_out + 4 (jal link value).
REQ-018 fetch_err  output  1  sticky: timeout or misaligned jr occurred.

Function
REQ-019 FSM states: S_IDLE, S_REQ, S_VALID.
REQ-020 S_IDLE: entered on reset; unconditionally moves to S_REQ next cycle.
REQ-021 S_REQ: imem_req=1, imem_addr=pc; hold until imem_ready=1, then latch imem_rdata into inst_data and move to S_VALID.
REQ-022 imem_ready while imem_req=0 is ignored.
REQ-023 S_VALID: inst_valid=1; if stall=0, PC loads next-PC at cycle end and FSM moves to S_REQ; if stall=1, FSM, PC and inst_data hold.
REQ-024 Next-PC: seq = pc+4; branch = pc+4 + (imm_data<<2); jump = {pc_plus4[31:28], addr_data}; jr = {jr_addr[31:2], 2'b00}.
REQ-025 All PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 without error.
REQ-026 pc_sel, imm_data, addr_data and jr_addr are sampled only in the S_VALID cycle with stall=0.
REQ-027 jr with jr_addr[1:0]!=0: low bits forced to 00 and fetch_err set.
REQ-028 Timeout counter: reset on S_REQ entry; increments each S_REQ cycle with imem_ready=0; on reaching IMEM_TIMEOUT it sets fetch_err and the request re-issues with the counter cleared.
REQ-029 fetch_err clears only on reset.
REQ-030 Fetch throughput: one instruction per 2 cycles with zero-wait memory (S_REQ with imem_ready=1, then S_VALID).
REQ-031 pc_plus4 combinationally equals pc_out+4 in all states.

Reset
REQ-032 On rst_n low, asynchronously: pc=RESET_PC, state=S_IDLE, imem_req=0, inst_valid=0, inst_data=32'h0, fetch_err=0, timeout counter=0.
REQ-033 Reset asserted mid-request aborts the request immediately; a response arriving after reset is ignored.
REQ-034 After rst_n deasserts, the first imem_req appears in the second rising edge's cycle (S_IDLE then S_REQ).

Structure
REQ-035 Shared package holds pc_sel encodings (PC_SEQ, PC_BR, PC_J, PC_JR), FSM state encodings, and the instruction width constant.
REQ-036 One combinational sub-module pc_next_gen computes next-PC from pc, pc_sel, imm_data, addr_data and jr_addr; the FSM, PC register and timeout logic live in inst_fetch.

Verification
REQ-037 Reset release, zero-wait memory returning 32'h2008_0005 -> imem_addr 0, then inst_valid=1, inst_data=32'h2008_0005, pc_out=0, pc_plus4=4.
REQ-038 pc_out=32'h0000_0010, pc_sel=01, imm_data=32'hFFFF_FFFE -> next imem_addr=32'h0000_000C.
REQ-039 pc_out=32'h4000_0000, pc_sel=10, addr_data=28'h000_0100 -> next imem_addr=32'h4000_0100; pc_sel=11, jr_addr=32'h0000_0023 -> imem_addr=32'h0000_0020, fetch_err=1.
REQ-040 stall=1 for 3 cycles in S_VALID -> inst_data, pc_out and inst_valid=1 held; no imem_req until stall drops.
REQ-041 imem_ready held 0 for 16 cycles -> fetch_err=1, imem_req stays 1; rst_n pulsed low mid-request -> imem_req=0 immediately, pc=RESET_PC, fetch_err=0.
REQ-042 pc_out=32'hFFFF_FFFC, pc_sel=00 -> next imem_addr=32'h0000_0000, fetch_err unchanged.
